// File: rtl/rx_demixer_pkg.sv
// -----------------------------------------------------------------------------
// rx_demixer_pkg
// Shared definitions for the fs/4 receive demixer and its transmit twin:
//   SAMPLE_WIDTH    - default real/IQ sample width
//   phase_e         - fs/4 carrier phase encodings (+I, +Q, -I, -Q)
//   SAT_MAX/SAT_MIN - two's complement limits of a SAMPLE_WIDTH sample
// -----------------------------------------------------------------------------
package rx_demixer_pkg;

    localparam int SAMPLE_WIDTH = 18;

    // Carrier phase order matches the transmitter: +I, +Q, -I, -Q
    typedef enum logic [1:0] {
        PH_I_POS = 2'd0,
        PH_Q_POS = 2'd1,
        PH_I_NEG = 2'd2,
        PH_Q_NEG = 2'd3
    } phase_e;

    localparam logic signed [SAMPLE_WIDTH-1:0] SAT_MAX = {1'b0, {(SAMPLE_WIDTH-1){1'b1}}};
    localparam logic signed [SAMPLE_WIDTH-1:0] SAT_MIN = {1'b1, {(SAMPLE_WIDTH-1){1'b0}}};

endpackage

// File: rtl/rx_demixer_sat_negate.sv
// -----------------------------------------------------------------------------
// sat_negate
// Combinational saturating two's complement negation. The single value that
// has no positive counterpart (the most negative code) maps to the most
// positive code instead of wrapping back to itself.
// Ports:
//   din  - signed input sample, WIDTH bits
//   dout - signed -din, clamped to the WIDTH-bit range
// -----------------------------------------------------------------------------
module sat_negate #(
    parameter int WIDTH = 18
) (
    input  logic signed [WIDTH-1:0] din,
    output logic signed [WIDTH-1:0] dout
);

    localparam logic signed [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [WIDTH-1:0] MOST_POS = {1'b0, {(WIDTH-1){1'b1}}};

    // Plain negation everywhere except the most negative code, which would
    // otherwise overflow back to itself.
    always_comb begin
        if (din == MOST_NEG) begin
            dout = MOST_POS;
        end else begin
            dout = -din;
        end
    end

endmodule

// File: rtl/rx_demixer.sv
// -----------------------------------------------------------------------------
// rx_demixer
// Receive-side fs/4 quadrature demixer. The real channel stream carries
// +I, +Q, -I, -Q in successive clk cycles; this block splits it back into
// separate I and Q streams with per-branch valid strobes. The phase counter
// is realigned by sym_clk_en exactly like the transmitter's, so a loopback
// needs no extra alignment.
// Ports:
//   clk          - system clock
//   reset_n      - asynchronous active-low reset
//   sym_clk_en   - symbol-rate strobe, realigns the phase counter
//   rx_channel   - signed received real sample, one per clk
//   phase_offset - static phase correction for channel delay (0..3)
//   clr_err      - synchronous clear of phase_err (a same-cycle set wins)
//   rx_inph      - registered recovered in-phase sample
//   rx_quad      - registered recovered quadrature sample
//   inph_valid   - rx_inph updated this cycle
//   quad_valid   - rx_quad updated this cycle
//   aligned      - at least one sym_clk_en seen since reset
//   phase_err    - sticky: a sym_clk_en arrived off the 4-sample grid
// -----------------------------------------------------------------------------
module rx_demixer
    import rx_demixer_pkg::*;
#(
    parameter int WIDTH     = SAMPLE_WIDTH,
    parameter bit HOLD_MODE = 1'b1
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    sym_clk_en,
    input  logic signed [WIDTH-1:0] rx_channel,
    input  logic [1:0]              phase_offset,
    input  logic                    clr_err,
    output logic signed [WIDTH-1:0] rx_inph,
    output logic signed [WIDTH-1:0] rx_quad,
    output logic                    inph_valid,
    output logic                    quad_valid,
    output logic                    aligned,
    output logic                    phase_err
);

    logic [1:0]              count_4;
    logic [1:0]              phase_sum;
    phase_e                  eff_phase;
    logic signed [WIDTH-1:0] neg_sample;
    logic signed [WIDTH-1:0] inph_next;
    logic signed [WIDTH-1:0] quad_next;
    logic                    inph_valid_next;
    logic                    quad_valid_next;
    logic                    err_next;

    sat_negate #(
        .WIDTH (WIDTH)
    ) u_sat_negate (
        .din  (rx_channel),
        .dout (neg_sample)
    );

    // The phase used for this cycle's sample is the counter value before its
    // update, rotated by the static offset. The 2-bit sum wraps mod 4.
    always_comb begin
        phase_sum = count_4 + phase_offset;
        eff_phase = phase_e'(phase_sum);
    end

    // Route the sample to its owning branch. The other branch either keeps
    // its last value or is zeroed, which models multiplying by the 0 of the
    // carrier on that phase.
    always_comb begin
        inph_next       = HOLD_MODE ? rx_inph : '0;
        quad_next       = HOLD_MODE ? rx_quad : '0;
        inph_valid_next = 1'b0;
        quad_valid_next = 1'b0;
        case (eff_phase)
            PH_I_POS: begin
                inph_next       = rx_channel;
                inph_valid_next = 1'b1;
            end
            PH_Q_POS: begin
                quad_next       = rx_channel;
                quad_valid_next = 1'b1;
            end
            PH_I_NEG: begin
                inph_next       = neg_sample;
                inph_valid_next = 1'b1;
            end
            PH_Q_NEG: begin
                quad_next       = neg_sample;
                quad_valid_next = 1'b1;
            end
        endcase
    end

    // A strobe is only judged once the counter has been aligned by an earlier
    // strobe; on-grid strobes arrive when the counter sits at 3. A new error
    // takes priority over a clear in the same cycle.
    always_comb begin
        err_next = phase_err;
        if (sym_clk_en && aligned && (count_4 != 2'd3)) begin
            err_next = 1'b1;
        end else if (clr_err) begin
            err_next = 1'b0;
        end
    end

    // All state registers, including the registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_4    <= 2'd0;
            rx_inph    <= '0;
            rx_quad    <= '0;
            inph_valid <= 1'b0;
            quad_valid <= 1'b0;
            aligned    <= 1'b0;
            phase_err  <= 1'b0;
        end else begin
            count_4    <= sym_clk_en ? 2'd0 : count_4 + 2'd1;
            rx_inph    <= inph_next;
            rx_quad    <= quad_next;
            inph_valid <= inph_valid_next;
            quad_valid <= quad_valid_next;
            aligned    <= aligned | sym_clk_en;
            phase_err  <= err_next;
        end
    end

endmodule

// File: doc/rx_demixer.md
Name: rx_demixer

Overview:
- Receive-side counterpart of the transmit fs/4 quadrature mixer.
- Takes the real 18-bit channel sample stream, which follows the sequence +I, +Q, -I, -Q at clk rate, and recovers separate I and Q sample streams with per-branch valid strobes.
- Its fs/4 phase counter is realigned by sym_clk_en exactly as the transmitter's is, so back-to-back loopback needs no extra alignment logic.
- Sits between the channel model / ADC front end and the receive matched filters.

Parameters:
- WIDTH, 18, sample width for input and both outputs (signed two's complement).
- HOLD_MODE, 1, 1 = each output branch holds its last recovered sample on non-owning phases; 0 = the branch outputs 0 on non-owning phases (true product with the 0/±1 carrier).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- sym_clk_en  in  1  symbol-rate strobe; realigns the phase counter
- rx_channel  in  WIDTH  signed received real sample, one per clk
- phase_offset  in  2  static phase correction for channel delay, range 0..3
- clr_err  in  1  synchronous clear of phase_err
- rx_inph  out  WIDTH  signed recovered in-phase sample (registered)
- rx_quad  out  WIDTH  signed recovered quadrature sample (registered)
- inph_valid  out  1  one-cycle pulse: rx_inph updated this cycle
- quad_valid  out  1  one-cycle pulse: rx_quad updated this cycle
- aligned  out  1  at least one sym_clk_en seen since reset
- phase_err  out  1  sticky: sym_clk_en arrived off the 4-sample grid

Behaviour:
- Clock and reset: single clock domain. reset_n is asynchronous and active-low. While reset_n is low, every register and output is 0.
- Phase counter count_4 (2 bits):
  - On sym_clk_en, next value is 0.
  - Otherwise it increments and wraps 3 -> 0.
  - The value used for the sample in cycle t is the registered value at t, before the update. This matches the transmitter.
- Effective phase: p = (count_4 + phase_offset) mod 4, combinational, 2-bit wrap.
- Mapping of the sample x in cycle t, registered at the edge ending cycle t (latency 1 clk):
  - p=0: rx_inph <= x; inph_valid=1.
  - p=1: rx_quad <= x; quad_valid=1.
  - p=2: rx_inph <= neg(x); inph_valid=1.
  - p=3: rx_quad <= neg(x); quad_valid=1.
- Non-owning branch:
  - HOLD_MODE=1: the other branch keeps its value.
  - HOLD_MODE=0: the other branch is loaded with 0.
  - Its valid stays 0 in both modes.
- Negation: neg(x) = -x, saturated. neg(-2^(WIDTH-1)) = 2^(WIDTH-1)-1. No other width growth; outputs are always WIDTH bits.
- Exactly one of inph_valid / quad_valid is high every cycle after reset deasserts. Both are 0 while reset is asserted.
- aligned:
  - Set at the edge where sym_clk_en is first sampled high.
  - Cleared only by reset.
- phase_err:
  - Set when sym_clk_en=1, aligned=1 and count_4 != 3, i.e. the symbol period is not a multiple of 4.
  - Not set on the first sym_clk_en after reset.
- clr_err=1 clears phase_err. If a set condition and clr_err occur in the same cycle, set wins.
- phase_offset is sampled every cycle; changing it mid-stream takes effect on the next sample, with no flush.
- Reset mid-operation: all state returns to 0. Counter phase is reacquired on the next sym_clk_en, which counts as the "first" again for phase_err.

Decomposition:
- Shared defines include: sample width (18), the fs/4 phase encodings PH_I_POS=0, PH_Q_POS=1, PH_I_NEG=2, PH_Q_NEG=3, and the saturation constants SAT_MAX / SAT_MIN.
- The counter and alignment logic stays inline.
- One natural sub-module: sat_negate (WIDTH-parameterised combinational saturating negation). It is reusable by the transmitter's -I / -Q paths.

Test Plan:
- Reset values: hold reset_n=0 and drive random inputs -> all outputs 0. Release reset -> inph_valid pulses in the first cycle, then the valids alternate I, Q, I, Q.
- Loopback with transmitter: I=1000, Q=-500, sym_clk_en every 4 clk, offset 0, HOLD_MODE=1 -> after alignment, rx_inph=1000 and rx_quad=-500 steady. aligned=1, phase_err=0.
- Saturation: stream -131072 with p=2 -> rx_inph=131071. With p=0 -> rx_inph=-131072.
- Offset: identical stream with phase_offset=1 -> branch roles rotate one phase; rx_quad = the former I sample path. Verify against the mapping table for all 4 offsets.
- Phase error: sym_clk_en period 4 then one period of 5 -> phase_err rises at that strobe and stays high. Assert clr_err together with another off-grid strobe -> phase_err stays 1. clr_err alone -> 0.
- HOLD_MODE=0 and mid-run reset: the non-owning branch reads 0 each cycle. Pulse reset_n low for 2 clk mid-stream -> outputs 0 and aligned=0. The next sym_clk_en does not set phase_err.
